// File: rtl/apb_cdb_arb_pkg.sv
// Shared types and constants for the two-port CDB APB arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package apb_cdb_arb_pkg;

    // Master-side transfer phases. IDLE is the arbitration point.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    // Read data returned with the error response of an aborted transfer.
    localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Port indices: 0 is the diagnostic/TAP path, 1 is the NoC master.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // One-hot grant vector for a port index.
    function automatic logic [1:0] port_onehot(input logic idx);
        return (idx == PORT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/apb_cdb_arb_timeout.sv
// ACCESS-phase watchdog: counts master wait cycles and flags the last allowed one.
// Latency: expire is combinational from the count register (no input-to-output path).
// Backpressure: none; the counter saturates and only clears on clr.
//
// Ports:
//   apb_pclk, apb_preset : clock, asynchronous active-high reset
//   clr                  : zero the count (asserted while in SETUP, i.e. on ACCESS entry)
//   inc                  : one ACCESS cycle elapsed without m_pready
//   expire               : the current ACCESS cycle is the TIMEOUT_CYCLES-th one; if it
//                          also lacks m_pready the count reaches the limit at this edge
module apb_cdb_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic apb_pclk,
    input  logic apb_preset,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT      = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge apb_pclk or posedge apb_preset) begin
        if (apb_preset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Flagging one count early lets the FSM leave ACCESS on the same edge
    // the counter reaches TIMEOUT_CYCLES, so exactly TIMEOUT_CYCLES ACCESS
    // cycles elapse before the error response.
    assign expire = (count == LIMIT_LAST);

endmodule

// File: rtl/apb_cdb_arbiter.sv
// Round-robin arbiter sharing the CDB APB master between the TAP diagnostic path and the NoC master.
// Latency: 3 cycles request-to-pready with a zero-wait slave; +1 cycle per master wait state; new transfer every 4 cycles max.
// Backpressure: losing requester simply holds psel (pready stays 0); master wait states stall ACCESS.
//
// Ports:
//   apb_pclk, apb_preset     : clock, asynchronous active-high reset
//   s0_* / s1_*              : APB slave-side ports (0 = diagnostic/TAP, 1 = NoC)
//   m_*                      : registered APB master towards the CDB pins
//   arb_grant                : one-hot current owner, 0 when idle
// Optional feature: define APB_CDB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
// wait cycles with pslverr=1 and prdata=DEAD_BEEF. Without it ACCESS waits forever and
// pslverr is always 0.
module apb_cdb_arbiter
    import apb_cdb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  apb_pclk,
    input  logic                  apb_preset,

    input  logic                  s0_psel,
    input  logic                  s0_penable,
    input  logic                  s0_pwrite,
    input  logic [ADDR_WIDTH-1:0] s0_paddr,
    input  logic [DATA_WIDTH-1:0] s0_pwdata,
    output logic [DATA_WIDTH-1:0] s0_prdata,
    output logic                  s0_pready,
    output logic                  s0_pslverr,

    input  logic                  s1_psel,
    input  logic                  s1_penable,
    input  logic                  s1_pwrite,
    input  logic [ADDR_WIDTH-1:0] s1_paddr,
    input  logic [DATA_WIDTH-1:0] s1_pwdata,
    output logic [DATA_WIDTH-1:0] s1_prdata,
    output logic                  s1_pready,
    output logic                  s1_pslverr,

    output logic                  m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [ADDR_WIDTH-1:0] m_paddr,
    output logic [DATA_WIDTH-1:0] m_pwdata,
    input  logic [DATA_WIDTH-1:0] m_prdata,
    input  logic                  m_pready,

    output logic [1:0]            arb_grant
);

    arb_state_e            state;
    logic                  last_grant;   // index of the most recent winner
    logic                  owner;        // index of the port owning the current transfer
    logic                  req_any;
    logic                  win_idx;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  to_expire;

    // Arbitration only looks at psel; penable carries no information here.
    logic unused_penable;
    assign unused_penable = s0_penable ^ s1_penable;

    // Round-robin pick: on a tie the port that did not win last time goes.
    always_comb begin
        req_any = s0_psel | s1_psel;
        win_idx = PORT0;
        if (s0_psel && s1_psel) begin
            win_idx = ~last_grant;
        end else if (s1_psel) begin
            win_idx = PORT1;
        end
        // Writes return zero data to the requester.
        resp_rdata = m_pwrite ? '0 : m_prdata;
    end

`ifdef APB_CDB_ARB_TIMEOUT_EN
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_RDATA = DATA_WIDTH'(ARB_TIMEOUT_RDATA);

    logic to_clr;
    logic to_inc;
    assign to_clr = (state == SETUP);
    assign to_inc = (state == ACCESS) && !m_pready;

    apb_cdb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .apb_pclk   (apb_pclk),
        .apb_preset (apb_preset),
        .clr        (to_clr),
        .inc        (to_inc),
        .expire     (to_expire)
    );
`else
    // Watchdog absent: ACCESS waits for m_pready indefinitely.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign to_expire = 1'b0;
`endif

    always_ff @(posedge apb_pclk or posedge apb_preset) begin
        if (apb_preset) begin
            state      <= IDLE;
            last_grant <= PORT1;   // port 0 wins the first tie
            owner      <= PORT0;
            arb_grant  <= 2'b00;
            m_psel     <= 1'b0;
            m_penable  <= 1'b0;
            m_pwrite   <= 1'b0;
            m_paddr    <= '0;
            m_pwdata   <= '0;
            s0_pready  <= 1'b0;
            s0_prdata  <= '0;
            s0_pslverr <= 1'b0;
            s1_pready  <= 1'b0;
            s1_prdata  <= '0;
            s1_pslverr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        owner      <= win_idx;
                        last_grant <= win_idx;
                        arb_grant  <= port_onehot(win_idx);
                        m_paddr    <= (win_idx == PORT1) ? s1_paddr  : s0_paddr;
                        m_pwrite   <= (win_idx == PORT1) ? s1_pwrite : s0_pwrite;
                        m_pwdata   <= (win_idx == PORT1) ? s1_pwdata : s0_pwdata;
                        m_psel     <= 1'b1;
                        m_penable  <= 1'b0;
                        state      <= SETUP;
                    end
                end

                SETUP: begin
                    m_penable <= 1'b1;
                    state     <= ACCESS;
                end

                ACCESS: begin
                    // A late m_pready on the expiring cycle still wins.
                    if (m_pready) begin
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        state     <= RESP;
                        if (owner == PORT0) begin
                            s0_pready <= 1'b1;
                            s0_prdata <= resp_rdata;
                        end else begin
                            s1_pready <= 1'b1;
                            s1_prdata <= resp_rdata;
                        end
                    end else if (to_expire) begin
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        state     <= RESP;
`ifdef APB_CDB_ARB_TIMEOUT_EN
                        if (owner == PORT0) begin
                            s0_pready  <= 1'b1;
                            s0_prdata  <= TIMEOUT_RDATA;
                            s0_pslverr <= 1'b1;
                        end else begin
                            s1_pready  <= 1'b1;
                            s1_prdata  <= TIMEOUT_RDATA;
                            s1_pslverr <= 1'b1;
                        end
`endif
                    end
                end

                RESP: begin
                    // Single-cycle response pulse; master address/data keep their values.
                    s0_pready  <= 1'b0;
                    s0_prdata  <= '0;
                    s0_pslverr <= 1'b0;
                    s1_pready  <= 1'b0;
                    s1_prdata  <= '0;
                    s1_pslverr <= 1'b0;
                    arb_grant  <= 2'b00;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cdb_arbiter.sv
// Directed self-checking bench for apb_cdb_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Build with APB_CDB_ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_apb_cdb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          apb_pclk = 1'b0;
    logic          apb_preset;
    logic          s0_psel, s0_penable, s0_pwrite;
    logic [AW-1:0] s0_paddr;
    logic [DW-1:0] s0_pwdata, s0_prdata;
    logic          s0_pready, s0_pslverr;
    logic          s1_psel, s1_penable, s1_pwrite;
    logic [AW-1:0] s1_paddr;
    logic [DW-1:0] s1_pwdata, s1_prdata;
    logic          s1_pready, s1_pslverr;
    logic          m_psel, m_penable, m_pwrite;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata, m_prdata;
    logic          m_pready;
    logic [1:0]    arb_grant;

    int checks = 0;
    int errors = 0;

    always #5 apb_pclk = ~apb_pclk;

    apb_cdb_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .apb_pclk   (apb_pclk),
        .apb_preset (apb_preset),
        .s0_psel    (s0_psel),
        .s0_penable (s0_penable),
        .s0_pwrite  (s0_pwrite),
        .s0_paddr   (s0_paddr),
        .s0_pwdata  (s0_pwdata),
        .s0_prdata  (s0_prdata),
        .s0_pready  (s0_pready),
        .s0_pslverr (s0_pslverr),
        .s1_psel    (s1_psel),
        .s1_penable (s1_penable),
        .s1_pwrite  (s1_pwrite),
        .s1_paddr   (s1_paddr),
        .s1_pwdata  (s1_pwdata),
        .s1_prdata  (s1_prdata),
        .s1_pready  (s1_pready),
        .s1_pslverr (s1_pslverr),
        .m_psel     (m_psel),
        .m_penable  (m_penable),
        .m_pwrite   (m_pwrite),
        .m_paddr    (m_paddr),
        .m_pwdata   (m_pwdata),
        .m_prdata   (m_prdata),
        .m_pready   (m_pready),
        .arb_grant  (arb_grant)
    );

    task automatic step();
        @(posedge apb_pclk);
        #1;
    endtask

    task automatic test_reset();
        apb_preset = 1'b1;
        s0_psel = 0; s0_penable = 0; s0_pwrite = 0; s0_paddr = '0; s0_pwdata = '0;
        s1_psel = 0; s1_penable = 0; s1_pwrite = 0; s1_paddr = '0; s1_pwdata = '0;
        m_prdata = '0; m_pready = 0;
        step(); step();
        checks++;
        if ({m_psel, m_penable, m_pwrite, s0_pready, s0_pslverr, s1_pready, s1_pslverr} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0000000", {m_psel, m_penable, m_pwrite, s0_pready, s0_pslverr, s1_pready, s1_pslverr});
        end
        checks++;
        if (m_paddr !== 32'h0 || m_pwdata !== 32'h0 || s0_prdata !== 32'h0 || s1_prdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got paddr=%h pwdata=%h s0_prdata=%h s1_prdata=%h exp all 0", m_paddr, m_pwdata, s0_prdata, s1_prdata);
        end
        checks++;
        if (arb_grant !== 2'b00) begin
            errors++;
            $display("FAIL reset_grant got=%b exp=00", arb_grant);
        end
        apb_preset = 1'b0;
        step();
        checks++;
        if (m_psel !== 1'b0 || arb_grant !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_req got psel=%b grant=%b exp 0/00", m_psel, arb_grant);
        end
    endtask

    task automatic test_single_read();
        m_pready = 1; m_prdata = 32'h1234_5678;
        s0_psel = 1; s0_pwrite = 0; s0_paddr = 32'h0000_0010;
        step();
        checks++;
        if (m_psel !== 1'b1 || m_penable !== 1'b0 || arb_grant !== 2'b01) begin
            errors++;
            $display("FAIL rd_setup got psel=%b penable=%b grant=%b exp 1/0/01", m_psel, m_penable, arb_grant);
        end
        checks++;
        if (m_paddr !== 32'h0000_0010 || m_pwrite !== 1'b0) begin
            errors++;
            $display("FAIL rd_addr got paddr=%h pwrite=%b exp 00000010/0", m_paddr, m_pwrite);
        end
        s0_penable = 1;
        step();
        checks++;
        if (m_psel !== 1'b1 || m_penable !== 1'b1 || s0_pready !== 1'b0 || arb_grant !== 2'b01) begin
            errors++;
            $display("FAIL rd_access got psel=%b penable=%b pready=%b grant=%b exp 1/1/0/01", m_psel, m_penable, s0_pready, arb_grant);
        end
        step();
        checks++;
        if (s0_pready !== 1'b1 || s0_prdata !== 32'h1234_5678 || s0_pslverr !== 1'b0 || arb_grant !== 2'b01) begin
            errors++;
            $display("FAIL rd_resp got pready=%b prdata=%h pslverr=%b grant=%b exp 1/12345678/0/01", s0_pready, s0_prdata, s0_pslverr, arb_grant);
        end
        checks++;
        if (m_psel !== 1'b0 || m_penable !== 1'b0 || s1_pready !== 1'b0 || s1_prdata !== 32'h0) begin
            errors++;
            $display("FAIL rd_resp_side got mpsel=%b mpen=%b s1_pready=%b s1_prdata=%h exp 0/0/0/0", m_psel, m_penable, s1_pready, s1_prdata);
        end
        s0_psel = 0; s0_penable = 0;
        step();
        checks++;
        if (s0_pready !== 1'b0 || s0_prdata !== 32'h0 || arb_grant !== 2'b00 || m_paddr !== 32'h0000_0010) begin
            errors++;
            $display("FAIL rd_done got pready=%b prdata=%h grant=%b paddr=%h exp 0/0/00/00000010", s0_pready, s0_prdata, arb_grant, m_paddr);
        end
    endtask

    task automatic test_reset_mid();
        m_pready = 0;
        s0_psel = 1; s0_pwrite = 1; s0_paddr = 32'h0000_0044; s0_pwdata = 32'hCAFE_0001;
        step(); step();
        checks++;
        if (m_penable !== 1'b1 || arb_grant !== 2'b01) begin
            errors++;
            $display("FAIL rst_pre got penable=%b grant=%b exp 1/01", m_penable, arb_grant);
        end
        apb_preset = 1'b1;
        #1;
        checks++;
        if ({m_psel, m_penable, m_pwrite, arb_grant} !== 5'b0 || m_paddr !== 32'h0 || m_pwdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid got ctl=%b paddr=%h pwdata=%h exp 0", {m_psel, m_penable, m_pwrite, arb_grant}, m_paddr, m_pwdata);
        end
        s0_psel = 0;
        step();
        apb_preset = 1'b0;
        step();
        checks++;
        if (m_psel !== 1'b0 || s0_pready !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_replay got psel=%b pready=%b exp 0/0", m_psel, s0_pready);
        end
        s0_psel = 1; s1_psel = 1;
        step();
        checks++;
        if (arb_grant !== 2'b01) begin
            errors++;
            $display("FAIL rst_last_grant got=%b exp=01", arb_grant);
        end
        apb_preset = 1'b1; s0_psel = 0; s1_psel = 0;
        step();
        apb_preset = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        m_pready = 1; m_prdata = 32'h1111_2222;
        s0_psel = 1; s0_pwrite = 1; s0_paddr = 32'h0000_0020; s0_pwdata = 32'hA5A5_A5A5;
        s1_psel = 1; s1_pwrite = 0; s1_paddr = 32'h0000_0030; s1_pwdata = 32'h0;
        step();
        checks++;
        if (arb_grant !== 2'b01 || m_paddr !== 32'h20 || m_pwrite !== 1'b1 || m_pwdata !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL sim_first got grant=%b paddr=%h pwrite=%b pwdata=%h exp 01/20/1/a5a5a5a5", arb_grant, m_paddr, m_pwrite, m_pwdata);
        end
        step(); step();
        checks++;
        if (s0_pready !== 1'b1 || s0_prdata !== 32'h0 || s1_pready !== 1'b0) begin
            errors++;
            $display("FAIL sim_wr_resp got s0_pready=%b s0_prdata=%h s1_pready=%b exp 1/0/0", s0_pready, s0_prdata, s1_pready);
        end
        s0_psel = 0;
        step();
        checks++;
        if (arb_grant !== 2'b00 || m_pwdata !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL sim_gap got grant=%b pwdata=%h exp 00/a5a5a5a5", arb_grant, m_pwdata);
        end
        step();
        checks++;
        if (arb_grant !== 2'b10 || m_paddr !== 32'h30 || m_pwrite !== 1'b0) begin
            errors++;
            $display("FAIL sim_second got grant=%b paddr=%h pwrite=%b exp 10/30/0", arb_grant, m_paddr, m_pwrite);
        end
        // s0 asks again during s1's transfer; s1 stays pending after its response.
        s0_psel = 1; s0_paddr = 32'h0000_0024; s0_pwdata = 32'h5A5A_5A5A;
        step(); step();
        checks++;
        if (s1_pready !== 1'b1 || s1_prdata !== 32'h1111_2222 || s0_pready !== 1'b0) begin
            errors++;
            $display("FAIL sim_rd_resp got s1_pready=%b s1_prdata=%h s0_pready=%b exp 1/11112222/0", s1_pready, s1_prdata, s0_pready);
        end
        step(); step();
        checks++;
        if (arb_grant !== 2'b01 || m_paddr !== 32'h24) begin
            errors++;
            $display("FAIL sim_rr_s0 got grant=%b paddr=%h exp 01/24", arb_grant, m_paddr);
        end
        step(); step();
        checks++;
        if (s0_pready !== 1'b1) begin
            errors++;
            $display("FAIL sim_third_resp got s0_pready=%b exp 1", s0_pready);
        end
        // s0 keeps psel high (back-to-back) while s1 is still pending: s1 must win.
        step(); step();
        checks++;
        if (arb_grant !== 2'b10) begin
            errors++;
            $display("FAIL b2b_rr got grant=%b exp 10", arb_grant);
        end
        s0_psel = 0;
        step(); step();
        checks++;
        if (s1_pready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_resp got s1_pready=%b exp 1", s1_pready);
        end
        s1_psel = 0;
        step();
    endtask

    task automatic test_wait_states();
        logic bad;
        bad = 1'b0;
        m_pready = 0; m_prdata = 32'h0BAD_CAFE;
        s1_psel = 1; s1_pwrite = 0; s1_paddr = 32'h0000_0060; s1_pwdata = 32'hBEEF_0060;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (s1_pready !== 1'b0 || m_psel !== 1'b1 || m_paddr !== 32'h60 || m_pwdata !== 32'hBEEF_0060)
                bad = 1'b1;
            if (k == 7) m_pready = 1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL ws_hold got bad=%b exp 0 (pready=%b paddr=%h pwdata=%h)", bad, s1_pready, m_paddr, m_pwdata);
        end
        step();
        checks++;
        if (s1_pready !== 1'b1 || s1_prdata !== 32'h0BAD_CAFE || s1_pslverr !== 1'b0) begin
            errors++;
            $display("FAIL ws_resp got pready=%b prdata=%h pslverr=%b exp 1/0badcafe/0", s1_pready, s1_prdata, s1_pslverr);
        end
        s1_psel = 0; m_pready = 0;
        step();
    endtask

`ifdef APB_CDB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic bad;
        bad = 1'b0;
        m_pready = 0; m_prdata = 32'h7777_7777;
        s0_psel = 1; s0_pwrite = 0; s0_paddr = 32'h0000_0050;
        step(); step();
        for (int k = 3; k <= 9; k++) begin
            step();
            if (s0_pready !== 1'b0 || m_penable !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL to_early got bad=%b exp 0", bad);
        end
        step();
        checks++;
        if (s0_pready !== 1'b1 || s0_pslverr !== 1'b1 || s0_prdata !== 32'hDEAD_BEEF || m_psel !== 1'b0) begin
            errors++;
            $display("FAIL to_resp got pready=%b pslverr=%b prdata=%h mpsel=%b exp 1/1/deadbeef/0", s0_pready, s0_pslverr, s0_prdata, m_psel);
        end
        s0_psel = 0;
        step();
        checks++;
        if (s0_pready !== 1'b0 || s0_pslverr !== 1'b0) begin
            errors++;
            $display("FAIL to_clear got pready=%b pslverr=%b exp 0/0", s0_pready, s0_pslverr);
        end
        // m_pready on the last allowed ACCESS cycle completes normally.
        bad = 1'b0;
        s0_psel = 1; s0_paddr = 32'h0000_0054;
        step(); step();
        for (int k = 3; k <= 9; k++) begin
            step();
            if (s0_pready !== 1'b0) bad = 1'b1;
            if (k == 9) begin m_pready = 1; m_prdata = 32'h600D_F00D; end
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL to_edge_early got bad=%b exp 0", bad);
        end
        step();
        checks++;
        if (s0_pready !== 1'b1 || s0_pslverr !== 1'b0 || s0_prdata !== 32'h600D_F00D) begin
            errors++;
            $display("FAIL to_edge_resp got pready=%b pslverr=%b prdata=%h exp 1/0/600df00d", s0_pready, s0_pslverr, s0_prdata);
        end
        s0_psel = 0; m_pready = 0;
        step();
    endtask
`else
    task automatic test_no_timeout();
        logic bad;
        bad = 1'b0;
        m_pready = 0; m_prdata = 32'h600D_F00D;
        s0_psel = 1; s0_pwrite = 0; s0_paddr = 32'h0000_0050;
        step(); step();
        for (int k = 0; k < 30; k++) begin
            step();
            if (s0_pready !== 1'b0 || s0_pslverr !== 1'b0 || m_psel !== 1'b1 || m_penable !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL nto_wait got bad=%b exp 0", bad);
        end
        m_pready = 1;
        step();
        checks++;
        if (s0_pready !== 1'b1 || s0_pslverr !== 1'b0 || s0_prdata !== 32'h600D_F00D) begin
            errors++;
            $display("FAIL nto_resp got pready=%b pslverr=%b prdata=%h exp 1/0/600df00d", s0_pready, s0_pslverr, s0_prdata);
        end
        s0_psel = 0; m_pready = 0;
        step();
    endtask
`endif

    task automatic test_protocol_violation();
        int pulses;
        pulses = 0;
        m_pready = 0;
        s0_psel = 1; s0_pwrite = 0; s0_paddr = 32'h0000_0070;
        s1_psel = 1; s1_pwrite = 0; s1_paddr = 32'h0000_0080;
        step();
        checks++;
        if (arb_grant !== 2'b01) begin
            errors++;
            $display("FAIL pv_grant got=%b exp=01", arb_grant);
        end
        step();
        s0_psel = 0;   // requester abandons mid-ACCESS
        step(); step();
        checks++;
        if (m_psel !== 1'b1 || m_penable !== 1'b1 || m_paddr !== 32'h70) begin
            errors++;
            $display("FAIL pv_continue got psel=%b penable=%b paddr=%h exp 1/1/70", m_psel, m_penable, m_paddr);
        end
        m_pready = 1; m_prdata = 32'h0000_ABCD;
        step();
        checks++;
        if (s0_pready !== 1'b1 || s0_prdata !== 32'h0000_ABCD) begin
            errors++;
            $display("FAIL pv_resp got pready=%b prdata=%h exp 1/0000abcd", s0_pready, s0_prdata);
        end
        m_pready = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (s0_pready === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL pv_single_pulse got extra=%0d exp 0", pulses);
        end
        checks++;
        if (arb_grant !== 2'b10 || m_paddr !== 32'h80) begin
            errors++;
            $display("FAIL pv_next got grant=%b paddr=%h exp 10/80", arb_grant, m_paddr);
        end
        m_pready = 1;
        step(); step();
        checks++;
        if (s1_pready !== 1'b1 || s0_pready !== 1'b0) begin
            errors++;
            $display("FAIL pv_s1_resp got s1_pready=%b s0_pready=%b exp 1/0", s1_pready, s0_pready);
        end
        s1_psel = 0; m_pready = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_reset_mid();
        test_simultaneous();
`ifdef APB_CDB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_wait_states();
        test_protocol_violation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=bench completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/apb_cdb_arbiter.md
# apb_cdb_arbiter

Two-port APB arbiter that shares the single CDB APB master interface between the TAP-driven diagnostic APB path (after its async-to-`apb_pclk` bridge) and the NoC-side APB master. It sits between the APB testchip wrapper's synchronous outputs and the `cdb_*` pins. It serialises transfers with round-robin fairness, registers all master-side signals, and optionally aborts hung transfers with an error response.

## Interface
- `ADDR_WIDTH`, 32: APB address width.
- `DATA_WIDTH`, 32: APB data width.
- `TIMEOUT_CYCLES`, 1024: ACCESS-phase cycles without `m_pready` before abort (≥2). Used only with the timeout macro.

Ports:
- `apb_pclk`  in  1  sole clock; all state on rising edge.
- `apb_preset`  in  1  asynchronous, active-high reset.
- `s0_psel`, `s0_penable`, `s0_pwrite`  in  1 each  port 0 (diagnostic/TAP, index 0) APB controls.
- `s0_paddr`  in  ADDR_WIDTH  port 0 address.
- `s0_pwdata`  in  DATA_WIDTH  port 0 write data.
- `s0_prdata`  out  DATA_WIDTH  port 0 read data.
- `s0_pready`  out  1  port 0 ready.
- `s0_pslverr`  out  1  port 0 error.
- `s1_*`: same set as `s0_*`, for the NoC master (index 1).
- `m_psel`, `m_penable`, `m_pwrite`  out  1 each  CDB master controls.
- `m_paddr`  out  ADDR_WIDTH  CDB address.
- `m_pwdata`  out  DATA_WIDTH  CDB write data.
- `m_prdata`  in  DATA_WIDTH  CDB read data.
- `m_pready`  in  1  CDB ready.
- `arb_grant`  out  2  one-hot current owner; 0 when idle.

## Operation
- **States:** IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- **Reset values:** every output is 0. `last_grant` resets to 1, so port 0 wins the first tie.
- **Request:** `sN_psel`=1 while in IDLE. `sN_penable` is not required for arbitration.
- **IDLE:**
  - Single requester: that requester is granted.
  - Both requesting: grant goes to the port ≠ `last_grant`.
  - On grant: capture paddr/pwrite/pwdata from the winner, update `last_grant`, set `arb_grant`, go to SETUP.
  - No request: stay in IDLE.
- **SETUP:** `m_psel`=1, `m_penable`=0 for exactly one cycle, then go to ACCESS.
- **ACCESS:**
  - `m_psel`=1, `m_penable`=1.
  - On `m_pready`=1: capture `m_prdata` (reads only; writes capture 0) and go to RESP.
- **RESP:**
  - `m_psel` and `m_penable` are deasserted.
  - The granted port sees `sN_pready`=1 for exactly one cycle, with captured prdata and `sN_pslverr` per the timeout rules.
  - Go to IDLE and clear `arb_grant`.
- **Non-granted port:** `pready`=0, `prdata`=0, `pslverr`=0 at all times.
- **Requester drops psel mid-transfer (protocol violation):** the master transfer still completes and the RESP pulse is still issued. It is not cancelled.
- **Back-to-back:** a port re-requesting in the IDLE cycle after its RESP loses to a pending other port (round-robin).
- **Master-side signals:** `m_paddr`/`m_pwrite`/`m_pwdata` hold captured values from SETUP through ACCESS. In IDLE and RESP they hold their last values.
- **Reset mid-transfer:** `apb_preset` forces IDLE and zeroes all outputs immediately. Nothing is replayed.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- **Minimum latency:** request sampled in IDLE at edge N.
  - `m_psel` high after N.
  - `m_penable` high after N+1.
  - If `m_pready`=1 at edge N+2, `sN_pready` is high after N+2, i.e. 3 cycles from request to response.
- **Throughput:** a new transfer can start every 4 cycles at most.
- **Master wait states:** each cycle of `m_pready`=0 adds exactly 1 cycle.

## Configuration
- Macro: `APB_CDB_ARB_TIMEOUT_EN`.
- **Defined:**
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit counter clears on entering ACCESS and increments on each ACCESS cycle with `m_pready`=0.
  - When it reaches TIMEOUT_CYCLES, the arbiter leaves ACCESS for RESP.
  - The RESP cycle gives `sN_pslverr`=1 and `sN_prdata`=32'hDEAD_BEEF (zero-extended or truncated to DATA_WIDTH).
  - `m_pready` arriving in the same cycle the count hits the limit wins: normal completion, no error.
- **Undefined:** no counter is implemented, ACCESS waits indefinitely, and `sN_pslverr` is constant 0.

## Structure
- Package `apb_cdb_arb_pkg`:
  - state enum `arb_state_e` (IDLE/SETUP/ACCESS/RESP);
  - `ARB_TIMEOUT_RDATA` = 32'hDEAD_BEEF;
  - port index localparams.
- Sub-module `apb_cdb_arb_timeout`: counter plus terminal-count flag, instantiated only under the macro.
- The FSM, capture registers and round-robin pointer stay in the top module.

## Test plan
- **Reset:** assert `apb_preset` mid-ACCESS → all outputs 0 next cycle; state IDLE; `last_grant`=1.
- **Single read:** s0 reads 0x0000_0010, CDB returns 0x1234_5678 with zero wait → `m_psel` at +1, `m_penable` at +2; `s0_pready`=1 and `s0_prdata`=0x1234_5678 at +3; `arb_grant`=01 throughout.
- **Simultaneous requests from reset:** s0 write 0xA5A5_A5A5 and s1 read → s0 served first, then s1; a third s0 request during s1's RESP loses only if s1 is pending again.
- **Wait states:** `m_pready` low 5 cycles → `s1_pready` occurs exactly 5 cycles later than zero-wait; `m_paddr`/`m_pwdata` stable throughout.
- **Timeout (macro on, TIMEOUT_CYCLES=8):** `m_pready` never asserted → RESP after 8 ACCESS cycles with `pslverr`=1, `prdata`=0xDEAD_BEEF. `m_pready` on the 8th cycle → normal response, `pslverr`=0.
- **Protocol violation:** s0 drops psel during ACCESS → master transfer completes, one `s0_pready` pulse, then pending s1 is granted.
